// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word requests with credit-based flow control,
// buffers returned words for decode. Optional misaligned-redirect trap: FETCH_MISALIGN_EN.
module inst_fetch_unit #(
  parameter int                             WIDTH_INST_LENGTH = 32,
  parameter int                             WIDTH_ADDR_LENGTH = 32,
  parameter logic [WIDTH_ADDR_LENGTH-1:0]   RESET_PC          = 32'h0000_0000,
  parameter int                             BUF_DEPTH         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          IMemReq,
  output logic [WIDTH_ADDR_LENGTH-1:0]  IMemAddr,
  input  logic                          IMemGnt,
  input  logic                          IMemRspValid,
  input  logic [WIDTH_INST_LENGTH-1:0]  IMemRspData,
  input  logic                          Redirect,
  input  logic [WIDTH_ADDR_LENGTH-1:0]  RedirectPC,
  output logic                          InstValid,
  input  logic                          InstReady,
  output logic [WIDTH_INST_LENGTH-1:0]  Inst,
  output logic [WIDTH_ADDR_LENGTH-1:0]  InstPC
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                          InstMisalign
`endif
);

  localparam int                          PTR_W    = $clog2(BUF_DEPTH);
  localparam int                          CNT_W    = PTR_W + 1;
  localparam logic [CNT_W:0]              DEPTH_C  = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0]            CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]            CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]            PTR_ONE  = PTR_W'(1);
  localparam logic [WIDTH_ADDR_LENGTH-1:0] PC_STEP = WIDTH_ADDR_LENGTH'(4);
  localparam logic [WIDTH_ADDR_LENGTH-1:0] WORD_MASK = ~(WIDTH_ADDR_LENGTH'(3));

  logic [WIDTH_ADDR_LENGTH-1:0] reqPC_r;
  logic [WIDTH_ADDR_LENGTH-1:0] rspPC_r;
  logic [CNT_W-1:0]             outstanding_r;
  logic [CNT_W-1:0]             bufCount_r;
  logic [CNT_W-1:0]             dropCnt_r;
  logic [PTR_W-1:0]             wrPtr_r;
  logic [PTR_W-1:0]             rdPtr_r;
  logic [WIDTH_INST_LENGTH-1:0] bufInst_r [BUF_DEPTH];
  logic [WIDTH_ADDR_LENGTH-1:0] bufPC_r   [BUF_DEPTH];

  logic [WIDTH_ADDR_LENGTH-1:0] redirTarget_s;
  logic [CNT_W:0]               credit_s;
  logic [CNT_W-1:0]             rspDec_s;
  logic [CNT_W-1:0]             grantInc_s;
  logic [CNT_W-1:0]             pushInc_s;
  logic [CNT_W-1:0]             popDec_s;
  logic                         grant_s;
  logic                         push_s;
  logic                         pop_s;
  logic                         dropRsp_s;
  logic                         fetchHalt_s;

`ifdef FETCH_MISALIGN_EN
  logic misalign_r;
  logic redirMisalign_s;

  assign redirTarget_s   = RedirectPC;
  assign redirMisalign_s = (RedirectPC[1:0] != 2'b00);
  assign fetchHalt_s     = misalign_r;
  assign InstMisalign    = misalign_r;

  // Trap flag: set by a misaligned redirect, cleared only by an aligned one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (Redirect) begin
      misalign_r <= redirMisalign_s;
    end
  end
`else
  assign redirTarget_s = RedirectPC & WORD_MASK;
  assign fetchHalt_s   = 1'b0;
`endif

  // Request credit, handshake qualifiers and counter deltas
  always_comb begin
    credit_s   = {1'b0, outstanding_r} + {1'b0, bufCount_r};
    IMemReq    = !Redirect && (credit_s < DEPTH_C) && (dropCnt_r == CNT_ZERO) && !fetchHalt_s;
    IMemAddr   = reqPC_r;
    grant_s    = IMemReq && IMemGnt;
    // A response in a redirect cycle belongs to the old stream, as do DropCnt ones
    dropRsp_s  = IMemRspValid && (Redirect || (dropCnt_r != CNT_ZERO));
    push_s     = IMemRspValid && !dropRsp_s;
    pop_s      = InstValid && InstReady && !Redirect;
    rspDec_s   = IMemRspValid ? CNT_ONE : CNT_ZERO;
    grantInc_s = grant_s      ? CNT_ONE : CNT_ZERO;
    pushInc_s  = push_s       ? CNT_ONE : CNT_ZERO;
    popDec_s   = pop_s        ? CNT_ONE : CNT_ZERO;
  end

  assign InstValid = (bufCount_r != CNT_ZERO) && !fetchHalt_s;
  assign Inst      = bufInst_r[rdPtr_r];
  assign InstPC    = bufPC_r[rdPtr_r];

  // PCs, in-flight/drop accounting and FIFO pointers; redirect overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqPC_r       <= RESET_PC;
      rspPC_r       <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      bufCount_r    <= CNT_ZERO;
      dropCnt_r     <= CNT_ZERO;
      wrPtr_r       <= {PTR_W{1'b0}};
      rdPtr_r       <= {PTR_W{1'b0}};
    end else if (Redirect) begin
      reqPC_r       <= redirTarget_s;
      rspPC_r       <= redirTarget_s;
      outstanding_r <= outstanding_r - rspDec_s;
      dropCnt_r     <= outstanding_r - rspDec_s;
      bufCount_r    <= CNT_ZERO;
      wrPtr_r       <= {PTR_W{1'b0}};
      rdPtr_r       <= {PTR_W{1'b0}};
    end else begin
      if (grant_s) begin
        reqPC_r <= reqPC_r + PC_STEP;
      end
      if (push_s) begin
        rspPC_r <= rspPC_r + PC_STEP;
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      if (dropRsp_s) begin
        dropCnt_r <= dropCnt_r - CNT_ONE;
      end
      outstanding_r <= outstanding_r + grantInc_s - rspDec_s;
      bufCount_r    <= bufCount_r + pushInc_s - popDec_s;
    end
  end

  // Buffer storage; cleared at reset so Inst/InstPC read zero before the first fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        bufInst_r[i] <= {WIDTH_INST_LENGTH{1'b0}};
        bufPC_r[i]   <= {WIDTH_ADDR_LENGTH{1'b0}};
      end
    end else if (push_s) begin
      bufInst_r[wrPtr_r] <= IMemRspData;
      bufPC_r[wrPtr_r]   <= rspPC_r;
    end
  end

endmodule
